control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 clr  in  1  reset, asynchronous, active-high.
REQ-003 opcode  in  5  IR[31:27] from datapath, valid from T3 until next T2.
REQ-004 stop  in  1  halt request, sampled at the last state of each instruction.
REQ-005 read, write  out  1 each  memory strobes toward MDR/memory.
REQ-006 PCout, Zlowout, Zhighout, MDRout, Cout, LOout, HIout, BAout, Rout  out  1 each  bus drive enables.
REQ-007 MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, RIn, IncPC  out  1 each  register load / PC increment enables.
REQ-008 Gra, Grb, Grc  out  1 each  register-field selects.
REQ-009 add, subtract, multiply, divide, andSignal, orSignal  out  1 each  ALU operation selects, one-hot or all zero.
REQ-010 run  out  1  high except in RESET and HALT.
REQ-011 illegal  out  1  high in HALT when entered on an undefined opcode.

Function
REQ-012 States: RESET, T0..T7, HALT; one state per clock, outputs Moore-decoded from (state, opcode), glitch-free per cycle.
REQ-013 RESET -> T0 on first rising edge with clr low.
REQ-014 T0: PCout, MARIn, IncPC, ZIn.  T1: Zlowout, PCIn, read, MDRIn.  T2: MDRout, IRIn.  T2 -> T3 always.
REQ-015 add/sub/and/or (opcodes 00011/00100/01001/01010): T3 Grb,Rout,YIn; T4 Grc,Rout,op,ZIn; T5 Zlowout,Gra,RIn; T5 is last.
REQ-016 mul/div (01110/01111): T3 Gra,Rout,YIn; T4 Grb,Rout,op,ZIn; T5 Zlowout,LoIn; T6 Zhighout,HiIn; T6 is last.
REQ-017 mfhi (10111): T3 Gra,RIn,HIout, last.  mflo (11000): T3 Gra,RIn,LOout, last.
REQ-018 ld (00000): T3 Grb,BAout,YIn; T4 Cout,add,ZIn; T5 Zlowout,MARIn; T6 read,MDRIn; T7 MDRout,Gra,RIn, last.
REQ-019 st (00010): T3-T5 as ld; T6 Gra,Rout,MDRIn; T7 write, last.
REQ-020 nop (11001): T3 all outputs low, last.  halt (11010): T3 -> HALT.
REQ-021 Any other opcode: T3 -> HALT, illegal=1, no register/memory enable asserted in T3.
REQ-022 Last state -> T0 if stop=0, -> HALT if stop=1; stop ignored in all other states.
REQ-023 HALT: all control outputs 0, run=0, held until clr.
REQ-024 At most one bus drive enable (REQ-006) high in any state; read and write never both high.
REQ-025 Instruction latency in clocks: ALU 6, mul/div 7, mfhi/mflo/nop 4, ld/st 8.

Reset
REQ-026 clr high forces RESET immediately, independent of clk, including mid-instruction and mid-memory-access.
REQ-027 In RESET every output is 0 (run=0, illegal=0); no partial instruction resumes after reset.

Structure
REQ-028 Shared package holds the state enumeration, the 5-bit opcode constants, and the instruction-length constants.
REQ-029 Single module: one state register, one next-state block, one output decode; no sub-module.

Verification
REQ-030 Reset then opcode=00011 (add), stop=0 -> T0..T5 with REQ-014/015 enables per cycle, back to T0 on 7th edge after reset release.
REQ-031 opcode=01110 (mul) -> LoIn only in T5, HiIn only in T6, multiply only in T4, return to T0 after T6.
REQ-032 opcode=00000 (ld) then 00010 (st) -> read high in T1 and T6 of ld; write high only in T7 of st; 8 clocks each.
REQ-033 opcode=10111 (mfhi) with stop=1 at T3 -> HIout,Gra,RIn in T3, then HALT, run=0; opcode changes ignored.
REQ-034 opcode=11111 -> HALT after T3, illegal=1, no RIn/write asserted; clr pulse -> RESET, illegal=0, T0 next.
REQ-035 clr asserted asynchronously during T6 of ld -> all outputs 0 before next edge; restart at T0 after release.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: state encoding, opcode map,
// instruction lengths and opcode classification helpers.
package control_unit_pkg;

    // Timing states occupy codes 0..7 so that the step index is the state value.
    typedef enum logic [3:0] {
        S_T0    = 4'd0,
        S_T1    = 4'd1,
        S_T2    = 4'd2,
        S_T3    = 4'd3,
        S_T4    = 4'd4,
        S_T5    = 4'd5,
        S_T6    = 4'd6,
        S_T7    = 4'd7,
        S_RESET = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    // Instruction lengths in clocks, fetch included.
    localparam int LEN_ALU    = 6;
    localparam int LEN_MULDIV = 7;
    localparam int LEN_MOVE   = 4;
    localparam int LEN_MEM    = 8;

    typedef enum logic [3:0] {
        C_ALU,
        C_MULDIV,
        C_MFHI,
        C_MFLO,
        C_LD,
        C_ST,
        C_NOP,
        C_HALT,
        C_ILLEGAL
    } op_class_t;

    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t c;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: c = C_ALU;
            OP_MUL, OP_DIV:                c = C_MULDIV;
            OP_MFHI:                       c = C_MFHI;
            OP_MFLO:                       c = C_MFLO;
            OP_LD:                         c = C_LD;
            OP_ST:                         c = C_ST;
            OP_NOP:                        c = C_NOP;
            OP_HALT:                       c = C_HALT;
            default:                       c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    // Final timing state of each class; halt and illegal never get past T3.
    function automatic state_t last_state(input op_class_t c);
        state_t s;
        case (c)
            C_ALU:              s = state_t'(4'(LEN_ALU - 1));
            C_MULDIV:           s = state_t'(4'(LEN_MULDIV - 1));
            C_MFHI, C_MFLO,
            C_NOP:              s = state_t'(4'(LEN_MOVE - 1));
            C_LD, C_ST:         s = state_t'(4'(LEN_MEM - 1));
            default:            s = S_T3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore control unit: fetch in T0-T2, per-opcode execute in T3-T7,
// with halt on request, halt opcode or undefined opcode.
module control_unit
    import control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [4:0] opcode,
    input  logic       stop,
    output logic       read,
    output logic       write,
    output logic       PCout,
    output logic       Zlowout,
    output logic       Zhighout,
    output logic       MDRout,
    output logic       Cout,
    output logic       LOout,
    output logic       HIout,
    output logic       BAout,
    output logic       Rout,
    output logic       MARIn,
    output logic       PCIn,
    output logic       MDRIn,
    output logic       IRIn,
    output logic       YIn,
    output logic       ZIn,
    output logic       HiIn,
    output logic       LoIn,
    output logic       RIn,
    output logic       IncPC,
    output logic       Gra,
    output logic       Grb,
    output logic       Grc,
    output logic       add,
    output logic       subtract,
    output logic       multiply,
    output logic       divide,
    output logic       andSignal,
    output logic       orSignal,
    output logic       run,
    output logic       illegal
);

    state_t    state_reg;
    state_t    state_next;
    op_class_t op_class;
    logic      illegal_reg;

    assign op_class = classify(opcode);

    // The illegal flag is captured as T3 is left so HALT remembers why it was entered.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg   <= S_RESET;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_T3) begin
                illegal_reg <= (op_class == C_ILLEGAL);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_RESET: state_next = S_T0;
            S_T0:    state_next = S_T1;
            S_T1:    state_next = S_T2;
            S_T2:    state_next = S_T3;
            S_HALT:  state_next = S_HALT;
            default: begin
                if (op_class == C_HALT || op_class == C_ILLEGAL) begin
                    state_next = S_HALT;
                end else if (state_reg == last_state(op_class)) begin
                    state_next = stop ? S_HALT : S_T0;
                end else begin
                    state_next = state_t'(state_reg + 4'd1);
                end
            end
        endcase
    end

    always_comb begin
        read      = 1'b0;
        write     = 1'b0;
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        MDRout    = 1'b0;
        Cout      = 1'b0;
        LOout     = 1'b0;
        HIout     = 1'b0;
        BAout     = 1'b0;
        Rout      = 1'b0;
        MARIn     = 1'b0;
        PCIn      = 1'b0;
        MDRIn     = 1'b0;
        IRIn      = 1'b0;
        YIn       = 1'b0;
        ZIn       = 1'b0;
        HiIn      = 1'b0;
        LoIn      = 1'b0;
        RIn       = 1'b0;
        IncPC     = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        add       = 1'b0;
        subtract  = 1'b0;
        multiply  = 1'b0;
        divide    = 1'b0;
        andSignal = 1'b0;
        orSignal  = 1'b0;

        case (state_reg)
            S_T0: begin
                PCout = 1'b1;
                MARIn = 1'b1;
                IncPC = 1'b1;
                ZIn   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCIn    = 1'b1;
                read    = 1'b1;
                MDRIn   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRIn   = 1'b1;
            end
            S_T3: begin
                case (op_class)
                    C_ALU: begin
                        Grb  = 1'b1;
                        Rout = 1'b1;
                        YIn  = 1'b1;
                    end
                    C_MULDIV: begin
                        Gra  = 1'b1;
                        Rout = 1'b1;
                        YIn  = 1'b1;
                    end
                    C_MFHI: begin
                        Gra   = 1'b1;
                        RIn   = 1'b1;
                        HIout = 1'b1;
                    end
                    C_MFLO: begin
                        Gra   = 1'b1;
                        RIn   = 1'b1;
                        LOout = 1'b1;
                    end
                    C_LD, C_ST: begin
                        Grb   = 1'b1;
                        BAout = 1'b1;
                        YIn   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (op_class)
                    C_ALU: begin
                        Grc       = 1'b1;
                        Rout      = 1'b1;
                        ZIn       = 1'b1;
                        add       = (opcode == OP_ADD);
                        subtract  = (opcode == OP_SUB);
                        andSignal = (opcode == OP_AND);
                        orSignal  = (opcode == OP_OR);
                    end
                    C_MULDIV: begin
                        Grb      = 1'b1;
                        Rout     = 1'b1;
                        ZIn      = 1'b1;
                        multiply = (opcode == OP_MUL);
                        divide   = (opcode == OP_DIV);
                    end
                    C_LD, C_ST: begin
                        Cout = 1'b1;
                        add  = 1'b1;
                        ZIn  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op_class)
                    C_ALU: begin
                        Zlowout = 1'b1;
                        Gra     = 1'b1;
                        RIn     = 1'b1;
                    end
                    C_MULDIV: begin
                        Zlowout = 1'b1;
                        LoIn    = 1'b1;
                    end
                    C_LD, C_ST: begin
                        Zlowout = 1'b1;
                        MARIn   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (op_class)
                    C_MULDIV: begin
                        Zhighout = 1'b1;
                        HiIn     = 1'b1;
                    end
                    C_LD: begin
                        read  = 1'b1;
                        MDRIn = 1'b1;
                    end
                    C_ST: begin
                        Gra   = 1'b1;
                        Rout  = 1'b1;
                        MDRIn = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (op_class)
                    C_LD: begin
                        MDRout = 1'b1;
                        Gra    = 1'b1;
                        RIn    = 1'b1;
                    end
                    C_ST: write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign run     = (state_reg != S_RESET) && (state_reg != S_HALT);
    assign illegal = (state_reg == S_HALT) && illegal_reg;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class cycle by cycle
// and compares every control output against hand-written per-state vectors.
module tb_control_unit;
    logic       clk;
    logic       clr;
    logic [4:0] opcode;
    logic       stop;
    logic read, write, PCout, Zlowout, Zhighout, MDRout, Cout, LOout, HIout, BAout, Rout;
    logic MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, RIn, IncPC;
    logic Gra, Grb, Grc, add, subtract, multiply, divide, andSignal, orSignal;
    logic run, illegal;

    int checks;
    int failures;

    logic [29:0] ctl;
    assign ctl = {read, write, PCout, Zlowout, Zhighout, MDRout, Cout, LOout, HIout, BAout,
                  Rout, MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, RIn, IncPC,
                  Gra, Grb, Grc, add, subtract, multiply, divide, andSignal, orSignal};

    localparam logic [29:0] K_READ     = 30'(1) << 29;
    localparam logic [29:0] K_WRITE    = 30'(1) << 28;
    localparam logic [29:0] K_PCOUT    = 30'(1) << 27;
    localparam logic [29:0] K_ZLOWOUT  = 30'(1) << 26;
    localparam logic [29:0] K_ZHIGHOUT = 30'(1) << 25;
    localparam logic [29:0] K_MDROUT   = 30'(1) << 24;
    localparam logic [29:0] K_COUT     = 30'(1) << 23;
    localparam logic [29:0] K_HIOUT    = 30'(1) << 21;
    localparam logic [29:0] K_BAOUT    = 30'(1) << 20;
    localparam logic [29:0] K_ROUT     = 30'(1) << 19;
    localparam logic [29:0] K_MARIN    = 30'(1) << 18;
    localparam logic [29:0] K_PCIN     = 30'(1) << 17;
    localparam logic [29:0] K_MDRIN    = 30'(1) << 16;
    localparam logic [29:0] K_IRIN     = 30'(1) << 15;
    localparam logic [29:0] K_YIN      = 30'(1) << 14;
    localparam logic [29:0] K_ZIN      = 30'(1) << 13;
    localparam logic [29:0] K_HIIN     = 30'(1) << 12;
    localparam logic [29:0] K_LOIN     = 30'(1) << 11;
    localparam logic [29:0] K_RIN      = 30'(1) << 10;
    localparam logic [29:0] K_INCPC    = 30'(1) << 9;
    localparam logic [29:0] K_GRA      = 30'(1) << 8;
    localparam logic [29:0] K_GRB      = 30'(1) << 7;
    localparam logic [29:0] K_GRC      = 30'(1) << 6;
    localparam logic [29:0] K_ADD      = 30'(1) << 5;
    localparam logic [29:0] K_MUL      = 30'(1) << 3;

    localparam logic [29:0] F0 = K_PCOUT | K_MARIN | K_INCPC | K_ZIN;
    localparam logic [29:0] F1 = K_ZLOWOUT | K_PCIN | K_READ | K_MDRIN;
    localparam logic [29:0] F2 = K_MDROUT | K_IRIN;

    control_unit dut (
        .clk(clk), .clr(clr), .opcode(opcode), .stop(stop),
        .read(read), .write(write), .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .MDRout(MDRout), .Cout(Cout), .LOout(LOout), .HIout(HIout), .BAout(BAout),
        .Rout(Rout), .MARIn(MARIn), .PCIn(PCIn), .MDRIn(MDRIn), .IRIn(IRIn), .YIn(YIn),
        .ZIn(ZIn), .HiIn(HiIn), .LoIn(LoIn), .RIn(RIn), .IncPC(IncPC),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .add(add), .subtract(subtract),
        .multiply(multiply), .divide(divide), .andSignal(andSignal), .orSignal(orSignal),
        .run(run), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        clr = 1'b1; stop = 1'b0; opcode = 5'b00000;
        repeat (2) @(negedge clk);
        checks++; if (ctl !== 30'h0) begin failures++; $display("FAIL reset_ctl got %h expected %h", ctl, 30'h0); end
        checks++; if (run !== 1'b0) begin failures++; $display("FAIL reset_run got %b expected 0", run); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got %b expected 0", illegal); end
        clr = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_add;
        logic [29:0] exp_v [6];
        exp_v = '{F0, F1, F2, K_GRB | K_ROUT | K_YIN, K_GRC | K_ROUT | K_ADD | K_ZIN,
                  K_ZLOWOUT | K_GRA | K_RIN};
        opcode = 5'b00011;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (ctl !== exp_v[i]) begin failures++; $display("FAIL add_t%0d got %h expected %h", i, ctl, exp_v[i]); end
            checks++; if (run !== 1'b1) begin failures++; $display("FAIL add_run_t%0d got %b expected 1", i, run); end
        end
        @(negedge clk);
        checks++; if (ctl !== F0) begin failures++; $display("FAIL add_return got %h expected %h", ctl, F0); end
        $display("test_add done");
    endtask

    task automatic test_mul;
        logic [29:0] exp_v [7];
        exp_v = '{F0, F1, F2, K_GRA | K_ROUT | K_YIN, K_GRB | K_ROUT | K_MUL | K_ZIN,
                  K_ZLOWOUT | K_LOIN, K_ZHIGHOUT | K_HIIN};
        opcode = 5'b01110;
        stop = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (ctl !== exp_v[i]) begin failures++; $display("FAIL mul_t%0d got %h expected %h", i, ctl, exp_v[i]); end
            if (i == 5) stop = 1'b0;
        end
        @(negedge clk);
        checks++; if (ctl !== F0) begin failures++; $display("FAIL mul_return got %h expected %h", ctl, F0); end
        $display("test_mul done");
    endtask

    task automatic test_back_to_back;
        logic [29:0] ld_v [8];
        logic [29:0] st_v [8];
        ld_v = '{F0, F1, F2, K_GRB | K_BAOUT | K_YIN, K_COUT | K_ADD | K_ZIN,
                 K_ZLOWOUT | K_MARIN, K_READ | K_MDRIN, K_MDROUT | K_GRA | K_RIN};
        st_v = '{F0, F1, F2, K_GRB | K_BAOUT | K_YIN, K_COUT | K_ADD | K_ZIN,
                 K_ZLOWOUT | K_MARIN, K_GRA | K_ROUT | K_MDRIN, K_WRITE};
        opcode = 5'b00000;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (ctl !== ld_v[i]) begin failures++; $display("FAIL ld_t%0d got %h expected %h", i, ctl, ld_v[i]); end
        end
        @(negedge clk);
        $display("ld done");
        opcode = 5'b00010;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (ctl !== st_v[i]) begin failures++; $display("FAIL st_t%0d got %h expected %h", i, ctl, st_v[i]); end
        end
        @(negedge clk);
        checks++; if (ctl !== F0) begin failures++; $display("FAIL st_return got %h expected %h", ctl, F0); end
        $display("st done");
    endtask

    task automatic test_nop_halt;
        logic [29:0] exp_v [4];
        exp_v = '{F0, F1, F2, 30'h0};
        opcode = 5'b11001;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (ctl !== exp_v[i]) begin failures++; $display("FAIL nop_t%0d got %h expected %h", i, ctl, exp_v[i]); end
        end
        checks++; if (run !== 1'b1) begin failures++; $display("FAIL nop_run got %b expected 1", run); end
        @(negedge clk);
        opcode = 5'b11010;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (ctl !== exp_v[i]) begin failures++; $display("FAIL halt_t%0d got %h expected %h", i, ctl, exp_v[i]); end
        end
        @(negedge clk);
        checks++; if (run !== 1'b0) begin failures++; $display("FAIL halt_run got %b expected 0", run); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL halt_illegal got %b expected 0", illegal); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        checks++; if (ctl !== F0) begin failures++; $display("FAIL halt_restart got %h expected %h", ctl, F0); end
        $display("test_nop_halt done");
    endtask

    task automatic test_mfhi_stop;
        logic [29:0] exp_v [4];
        exp_v = '{F0, F1, F2, K_HIOUT | K_GRA | K_RIN};
        opcode = 5'b10111;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (ctl !== exp_v[i]) begin failures++; $display("FAIL mfhi_t%0d got %h expected %h", i, ctl, exp_v[i]); end
            if (i == 2) stop = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (ctl !== 30'h0) begin failures++; $display("FAIL mfhi_halt%0d got %h expected %h", i, ctl, 30'h0); end
            checks++; if (run !== 1'b0) begin failures++; $display("FAIL mfhi_run%0d got %b expected 0", i, run); end
            opcode = (i == 0) ? 5'b00011 : 5'b00000;
        end
        stop = 1'b0;
        $display("test_mfhi_stop done");
    endtask

    task automatic test_illegal;
        logic [29:0] exp_v [4];
        exp_v = '{F0, F1, F2, 30'h0};
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        opcode = 5'b11111;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (ctl !== exp_v[i]) begin failures++; $display("FAIL ill_t%0d got %h expected %h", i, ctl, exp_v[i]); end
        end
        @(negedge clk);
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL ill_flag got %b expected 1", illegal); end
        checks++; if (run !== 1'b0) begin failures++; $display("FAIL ill_run got %b expected 0", run); end
        checks++; if (ctl !== 30'h0) begin failures++; $display("FAIL ill_ctl got %h expected %h", ctl, 30'h0); end
        @(negedge clk);
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL ill_hold got %b expected 1", illegal); end
        clr = 1'b1;
        #1;
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL ill_clr got %b expected 0", illegal); end
        @(negedge clk);
        clr = 1'b0;
        opcode = 5'b00000;
        @(negedge clk);
        checks++; if (ctl !== F0) begin failures++; $display("FAIL ill_restart got %h expected %h", ctl, F0); end
        $display("test_illegal done");
    endtask

    task automatic test_async_reset;
        logic [29:0] exp_v [7];
        exp_v = '{F0, F1, F2, K_GRB | K_BAOUT | K_YIN, K_COUT | K_ADD | K_ZIN,
                  K_ZLOWOUT | K_MARIN, K_READ | K_MDRIN};
        opcode = 5'b00000;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (ctl !== exp_v[i]) begin failures++; $display("FAIL async_t%0d got %h expected %h", i, ctl, exp_v[i]); end
        end
        #2;
        clr = 1'b1;
        #1;
        checks++; if (ctl !== 30'h0) begin failures++; $display("FAIL async_ctl got %h expected %h", ctl, 30'h0); end
        checks++; if (run !== 1'b0) begin failures++; $display("FAIL async_run got %b expected 0", run); end
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        checks++; if (ctl !== F0) begin failures++; $display("FAIL async_t0 got %h expected %h", ctl, F0); end
        @(negedge clk);
        checks++; if (ctl !== F1) begin failures++; $display("FAIL async_t1 got %h expected %h", ctl, F1); end
        $display("test_async_reset done");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_add();
        test_mul();
        test_back_to_back();
        test_nop_halt();
        test_mfhi_stop();
        test_illegal();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
